alu_rr_arbiter: RTL and testbench
=================================

// Module: alu_rr_arbiter
// PURPOSE
//  Shares one 4-bit add/OR/AND/XOR ALU among N_REQ requesters.
//  Each requester sends {a, b, op} on a valid/ready request channel. The block arbitrates
//  round-robin, runs one operation at a time, and returns the result on a per-requester
//  valid/ready response channel.
//  Sits between requester FSMs and the shared ALU datapath.
// PARAMETERS
//  N_REQ  2  number of requesters (2..4)
//  W      4  operand/result width in bits
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  req_valid  in   N_REQ    requester i presents an operation
//  req_ready  out  N_REQ    request accepted this cycle (one-hot or zero)
//  req_a      in   N_REQ*W  operand a, requester i at [i*W +: W]
//  req_b      in   N_REQ*W  operand b, same packing
//  req_op     in   N_REQ*2  op, requester i at [i*2 +: 2]
//  rsp_valid  out  N_REQ    result for requester i is valid (one-hot or zero)
//  rsp_ready  in   N_REQ    requester i takes the result
//  rsp_data   out  W        result; shared bus, meaningful only where rsp_valid is set
//  busy       out  1        high whenever state != IDLE
//  grant_id   out  2        index of the current/last granted requester
// BEHAVIOUR
//  Reset (rst_n=0, async):
//   - state=IDLE, rr_ptr=0, grant_id=0
//   - req_ready=0, rsp_valid=0, rsp_data=0, busy=0
//   - captured operands cleared
//  Op encoding:
//   - 00 ADD: (a+b) mod 2^W, carry dropped
//   - 01 OR, 10 AND, 11 XOR
//  FSM states: IDLE -> EXEC -> RESP -> IDLE
//  IDLE:
//   - g = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod N_REQ
//   - req_ready[g]=1 combinationally, only in IDLE and only if some valid is set
//   - handshake (valid & ready) on edge T:
//     - capture a/b/op of g
//     - grant_id<=g, go EXEC
//   - no valid: stay in IDLE, all req_ready=0
//  EXEC (1 cycle):
//   - registered ALU result of captured operands loaded into rsp_data; go RESP
//  RESP:
//   - rsp_valid[grant_id]=1; rsp_data held stable until rsp_ready[grant_id]=1
//   - on response handshake: rr_ptr<=(grant_id+1) mod N_REQ; go IDLE
//   - rsp_valid drops in the cycle after the handshake
//  Latency / throughput:
//   - request accepted at edge T -> rsp_valid high from cycle T+2
//   - one operation per 3 cycles at most (back-to-back with rsp_ready tied high)
//  Boundary conditions:
//   - Simultaneous requests: lowest index at or after rr_ptr wins; losers wait with
//     req_ready=0 and must keep valid and data stable.
//   - Requester may drop req_valid before ready; nothing is committed.
//   - req_valid inputs are ignored outside IDLE.
//   - rsp_ready inputs are ignored outside RESP and for non-granted indices.
//   - rr_ptr changes only on a completed response handshake.
//   - Reset mid-operation (EXEC/RESP): in-flight operation discarded, no response
//     issued, all outputs at reset values immediately.
//   - ADD overflow wraps silently: 4'hF+4'h1 = 4'h0.
// STRUCTURE
//  Package alu_arb_pkg:
//   - op localparams ALU_ADD/ALU_OR/ALU_AND/ALU_XOR = 2'b00..2'b11
//   - state encoding S_IDLE/S_EXEC/S_RESP
//  Sub-module alu_core (combinational, W-bit, same op encoding):
//   - instantiated once; the arbiter owns all registers
//   - round-robin pick is an internal function
// TESTING
//  T1 reset: assert rst_n=0 mid-run -> all outputs 0 in the same cycle; busy=0
//  T2 single request: r0 a=4'hA b=4'h7 op=00 -> rsp_valid[0] at T+2, rsp_data=4'h1
//  T3 contention: r0 and r1 valid together from reset -> r0 served first, then r1;
//     repeat with both valid -> r0 again (rr_ptr=0 after r1); grant_id 0,1,0
//  T4 backpressure: rsp_ready[1]=0 for 5 cycles -> rsp_valid[1] and rsp_data held
//     stable; req_ready=0 throughout
//  T5 all ops: a=4'hC b=4'hA -> ADD 4'h6, OR 4'hE, AND 4'h8, XOR 4'h6
//  T6 reset in EXEC: accept r1, pull rst_n low in EXEC -> no rsp_valid ever seen for r1

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared encodings for the round-robin ALU arbiter: ALU opcodes and FSM states.
package alu_arb_pkg;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_OR  = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_XOR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } state_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational W-bit ALU: ADD (carry dropped), OR, AND, XOR.
module alu_core
    import alu_arb_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [1:0]   op_i,
    output logic [W-1:0] res_o
);

    // Select the operation; the sum is truncated to W bits so overflow wraps.
    always_comb begin
        res_o = '0;
        case (op_i)
            ALU_ADD: res_o = a_i + b_i;
            ALU_OR:  res_o = a_i | b_i;
            ALU_AND: res_o = a_i & b_i;
            ALU_XOR: res_o = a_i ^ b_i;
            default: res_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one ALU among N_REQ requesters.
// IDLE grants one request, EXEC registers the ALU result, RESP holds it until
// the granted requester takes it; the pointer advances only on that handshake.
module alu_rr_arbiter
    import alu_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int W     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    input  logic [N_REQ*2-1:0] req_op,
    output logic [N_REQ-1:0]   rsp_valid,
    input  logic [N_REQ-1:0]   rsp_ready,
    output logic [W-1:0]       rsp_data,
    output logic               busy,
    output logic [1:0]         grant_id
);

    // Returns {found, index}: first valid requester scanning from ptr upwards, wrapping.
    function automatic logic [2:0] rr_pick(input logic [N_REQ-1:0] valid, input logic [1:0] ptr);
        logic [2:0] res;
        int         idx;
        res = 3'b000;
        // Scan from the farthest offset down so the nearest one to ptr wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (valid[idx]) begin
                res = {1'b1, idx[1:0]};
            end
        end
        return res;
    endfunction

    // Next pointer position after the given index, modulo N_REQ.
    function automatic logic [1:0] rr_inc(input logic [1:0] cur);
        int nxt;
        nxt = (int'(cur) + 1) % N_REQ;
        return nxt[1:0];
    endfunction

    state_e       state_q, state_d;
    logic [1:0]   rr_ptr_q, rr_ptr_d;
    logic [1:0]   grant_q, grant_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic [1:0]   op_q, op_d;
    logic [W-1:0] rsp_data_q, rsp_data_d;

    logic [2:0]   pick_s;
    logic         pick_found_s;
    logic [1:0]   pick_idx_s;
    logic [W-1:0] alu_res_s;
    logic         rsp_take_s;

    assign pick_s       = rr_pick(req_valid, rr_ptr_q);
    assign pick_found_s = pick_s[2];
    assign pick_idx_s   = pick_s[1:0];

    alu_core #(
        .W (W)
    ) u_alu_core (
        .a_i   (a_q),
        .b_i   (b_q),
        .op_i  (op_q),
        .res_o (alu_res_s)
    );

    // Only the granted requester's rsp_ready can complete a response.
    always_comb begin
        rsp_take_s = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if ((grant_q == i[1:0]) && rsp_ready[i]) begin
                rsp_take_s = 1'b1;
            end else begin
                rsp_take_s = rsp_take_s;
            end
        end
    end

    // Next-state, capture and request-ready logic of the arbiter FSM.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        rsp_data_d = rsp_data_q;
        req_ready  = '0;
        case (state_q)
            S_IDLE: begin
                if (pick_found_s) begin
                    // ready is raised only toward a valid requester, so the
                    // handshake always completes on this edge
                    for (int i = 0; i < N_REQ; i++) begin
                        req_ready[i] = (pick_idx_s == i[1:0]);
                    end
                    a_d     = req_a[int'(pick_idx_s)*W +: W];
                    b_d     = req_b[int'(pick_idx_s)*2*0 + int'(pick_idx_s)*W +: W];
                    op_d    = req_op[int'(pick_idx_s)*2 +: 2];
                    grant_d = pick_idx_s;
                    state_d = S_EXEC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EXEC: begin
                rsp_data_d = alu_res_s;
                state_d    = S_RESP;
            end
            S_RESP: begin
                if (rsp_take_s) begin
                    rr_ptr_d = rr_inc(grant_q);
                    state_d  = S_IDLE;
                end else begin
                    state_d  = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= 2'b00;
            grant_q    <= 2'b00;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= 2'b00;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    // Response valid is a one-hot decode of the registered grant while in RESP.
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rsp_valid[i] = (state_q == S_RESP) && (grant_q == i[1:0]);
        end
    end

    assign rsp_data = rsp_data_q;
    assign busy     = (state_q != S_IDLE);
    assign grant_id = grant_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Scoreboard bench for alu_rr_arbiter: directed requests push expected
// responses; a monitor pops and compares on every response handshake.
module tb_alu_rr_arbiter;
    import alu_arb_pkg::*;

    localparam int N_REQ = 2;
    localparam int W     = 4;

    typedef struct {
        int           idx;
        logic [W-1:0] data;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ*W-1:0] req_a;
    logic [N_REQ*W-1:0] req_b;
    logic [N_REQ*2-1:0] req_op;
    logic [N_REQ-1:0]   rsp_valid;
    logic [N_REQ-1:0]   rsp_ready;
    logic [W-1:0]       rsp_data;
    logic               busy;
    logic [1:0]         grant_id;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    alu_rr_arbiter #(.N_REQ(N_REQ), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every response handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (rsp_valid[i] && rsp_ready[i]) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_rsp: requester %0d data %0h, expected no response", i, rsp_data);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("rsp_idx", 8'(i), 8'(e.idx));
                        chk("rsp_data", 8'(rsp_data), 8'(e.data));
                    end
                end
            end
        end
    end

    task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        req_valid[i]     = 1'b1;
        req_a[i*W +: W]  = a;
        req_b[i*W +: W]  = b;
        req_op[i*2 +: 2] = op;
    endtask

    task automatic expect_rsp(input int i, input logic [3:0] d);
        exp_t e;
        e.idx  = i;
        e.data = d;
        sb.push_back(e);
    endtask

    // Called just after a rising edge with the DUT idle and rsp_ready all high.
    task automatic run_single(input int i, input logic [3:0] a, input logic [3:0] b,
                              input logic [1:0] op, input logic [3:0] exp);
        set_req(i, a, b, op);
        expect_rsp(i, exp);
        @(negedge clk);
        chk("idle_req_ready", 8'(req_ready), 8'(1 << i));
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        chk("exec_busy", 8'(busy), 8'h01);
        chk("exec_rsp_valid", 8'(rsp_valid), 8'h00);
        @(negedge clk);
        chk("resp_rsp_valid", 8'(rsp_valid), 8'(1 << i));
        chk("resp_grant_id", 8'(grant_id), 8'(i));
        @(negedge clk);
        chk("after_rsp_valid", 8'(rsp_valid), 8'h00);
        chk("after_busy", 8'(busy), 8'h00);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 8'(req_ready), 8'h00);
        chk("rst_rsp_valid", 8'(rsp_valid), 8'h00);
        chk("rst_rsp_data", 8'(rsp_data), 8'h00);
        chk("rst_busy", 8'(busy), 8'h00);
        chk("rst_grant_id", 8'(grant_id), 8'h00);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        rsp_ready = '1;

        // Single request and every op, including ADD wrap.
        run_single(0, 4'hA, 4'h7, ALU_ADD, 4'h1);
        run_single(0, 4'hC, 4'hA, ALU_ADD, 4'h6);
        run_single(0, 4'hC, 4'hA, ALU_OR,  4'hE);
        run_single(0, 4'hC, 4'hA, ALU_AND, 4'h8);
        run_single(0, 4'hC, 4'hA, ALU_XOR, 4'h6);
        run_single(0, 4'hF, 4'h1, ALU_ADD, 4'h0);

        // Reset while holding a response: outputs clear at once, operation dropped.
        rsp_ready = '0;
        set_req(0, 4'h5, 4'h5, ALU_OR);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        chk("held_rsp_valid", 8'(rsp_valid), 8'h01);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", 8'(rsp_valid), 8'h00);
        chk("midrst_busy", 8'(busy), 8'h00);
        chk("midrst_rsp_data", 8'(rsp_data), 8'h00);
        chk("midrst_grant_id", 8'(grant_id), 8'h00);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        rsp_ready = '1;

        // Contention from reset: r0, then r1, then r0 again.
        set_req(0, 4'h3, 4'h4, ALU_ADD);
        set_req(1, 4'h5, 4'h9, ALU_XOR);
        expect_rsp(0, 4'h7);
        @(negedge clk);
        chk("cont1_req_ready", 8'(req_ready), 8'h01);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("cont1_exec_ready", 8'(req_ready), 8'h00);
        @(negedge clk);
        chk("cont1_grant", 8'(grant_id), 8'h00);
        chk("cont1_resp_ready", 8'(req_ready), 8'h00);
        @(negedge clk);
        chk("cont2_req_ready", 8'(req_ready), 8'h02);
        expect_rsp(1, 4'hC);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        chk("cont2_grant", 8'(grant_id), 8'h01);
        @(negedge clk);
        @(posedge clk); #1;
        set_req(0, 4'h3, 4'h4, ALU_ADD);
        set_req(1, 4'h5, 4'h9, ALU_XOR);
        expect_rsp(0, 4'h7);
        @(negedge clk);
        chk("cont3_req_ready", 8'(req_ready), 8'h01);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        chk("cont3_grant", 8'(grant_id), 8'h00);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;

        // Backpressure on r1 while r0 waits with valid set.
        rsp_ready = 2'b01;
        set_req(1, 4'h6, 4'h3, ALU_AND);
        expect_rsp(1, 4'h2);
        @(posedge clk); #1;
        req_valid = '0;
        set_req(0, 4'h1, 4'h1, ALU_OR);
        expect_rsp(0, 4'h1);
        @(negedge clk);
        chk("bp_exec_ready", 8'(req_ready), 8'h00);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 8'(rsp_valid), 8'h02);
            chk("bp_rsp_data", 8'(rsp_data), 8'h02);
            chk("bp_req_ready", 8'(req_ready), 8'h00);
        end
        @(posedge clk); #1;
        rsp_ready = '1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_next_ready", 8'(req_ready), 8'h01);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        chk("bp_next_grant", 8'(grant_id), 8'h00);
        @(negedge clk);
        @(posedge clk); #1;

        // Reset during EXEC: accepted r1 must never respond.
        set_req(1, 4'h3, 4'h3, ALU_ADD);
        @(posedge clk); #1;
        req_valid = '0;
        chk("t6_exec_busy", 8'(busy), 8'h01);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", 8'(busy), 8'h00);
        chk("t6_rst_rsp_valid", 8'(rsp_valid), 8'h00);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t6_no_rsp", 8'(rsp_valid), 8'h00);
        end

        chk("sb_empty", 8'(sb.size()), 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
